// File: rtl/instr_fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package instr_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_stage_pc_register.sv
// Program-counter register: synchronous reset to RESET_PC, load enable plus data.
module pc_register #(
  parameter int unsigned           WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WORD_LEN-1:0] d,
  output logic [WORD_LEN-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)       q <= RESET_PC;
    else if (load) q <= d;
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// presents one instruction (or a bubble) per cycle to the IF->ID register.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   FETCH | request outstanding at pc; ack data passes straight through
//   HOLD  | downstream frozen; replay the captured word, no request
//   DROP  | redirected while a request was in flight; wait out its ack
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned         WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0,
  parameter int unsigned         PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_target,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] pc_out,
  output logic                fetch_bubble
);

  fetch_state_t        state, state_nxt;
  logic [WORD_LEN-1:0] pc, pc_nxt, pc_inc;
  logic                pc_load;
  logic [WORD_LEN-1:0] hold_reg, stale_addr;
  logic                hold_load, stale_load;

  assign pc_inc = pc + WORD_LEN'(PC_STEP);

  pc_register #(
    .WORD_LEN (WORD_LEN),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_nxt),
    .q    (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      hold_reg   <= '0;
      stale_addr <= '0;
    end else begin
      state <= state_nxt;
      if (hold_load)  hold_reg   <= imem_rdata;
      if (stale_load) stale_addr <= pc;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_load      = 1'b0;
    pc_nxt       = pc_inc;
    hold_load    = 1'b0;
    stale_load   = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = pc;
    instruction  = WORD_LEN'(NOP_WORD);
    pc_out       = pc;
    fetch_bubble = 1'b1;
    if (rst) begin
      pc_out = '0;
    end else begin
      // A redirect always loads the target; only the state transition differs.
      if (branch_taken) begin
        pc_load = 1'b1;
        pc_nxt  = branch_target;
      end
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (branch_taken) begin
            if (!imem_ack) begin
              stale_load = 1'b1;
              state_nxt  = DROP;
            end
          end else if (imem_ack) begin
            instruction  = imem_rdata;
            fetch_bubble = 1'b0;
            if (freeze) begin
              hold_load = 1'b1;
              state_nxt = HOLD;
            end else begin
              pc_load = 1'b1;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            state_nxt = FETCH;
          end else begin
            instruction  = hold_reg;
            fetch_bubble = 1'b0;
            if (!freeze) begin
              pc_load   = 1'b1;
              state_nxt = FETCH;
            end
          end
        end
        DROP: begin
          imem_req  = 1'b1;
          imem_addr = stale_addr;
          if (imem_ack) state_nxt = FETCH;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule
